// File: rtl/edib_m2_manchester_tx.sv
// rtl/edib_m2_manchester_tx.sv - EDIB M2 Manchester transmitter: sync + 16 data bits MSB first, complementary line pair.
// Define EDIB_M2_TX_PARITY_EN to append an odd-parity bit after the data LSB.
`timescale 1ns/1ps
module edib_m2_manchester_tx #(
  parameter int HALF_DIV = 6,
  parameter int GAP_BITS = 4
) (
  input  logic        clk_12m,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] tx_data,
  input  logic        tx_cmd,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int HCW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF_DIV - 1);
  localparam logic [4:0]     GAP_LAST  = 5'(2 * GAP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY, S_GAP} state_t;

  state_t         r_state, w_state_nx;
  logic [HCW-1:0] r_half_cnt, w_half_nx;
  logic [4:0]     r_bit_cnt, w_bit_nx;
  logic           r_second, w_second_nx;
  logic [15:0]    r_data, w_data_nx;
  logic           r_cmd, w_cmd_nx;
  logic           r_ready, r_p, r_n, r_busy, r_done;
  logic           w_hs, w_tick, w_line_nx, w_drive_nx;
`ifdef EDIB_M2_TX_PARITY_EN
  logic           r_par;
`endif

  assign w_hs   = tx_valid & r_ready;
  assign w_tick = (r_half_cnt == HALF_LAST);

  // In SYNC and GAP the bit counter counts half-bits; in DATA it counts bits.
  always_comb begin
    w_state_nx  = r_state;
    w_bit_nx    = r_bit_cnt;
    w_second_nx = r_second;
    w_data_nx   = r_data;
    w_cmd_nx    = r_cmd;
    w_half_nx   = (r_state == S_IDLE || w_tick) ? '0 : r_half_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_state_nx  = S_SYNC;
          w_bit_nx    = '0;
          w_second_nx = 1'b0;
          w_data_nx   = tx_data;
          w_cmd_nx    = tx_cmd;
        end
      end
      S_SYNC: begin
        if (w_tick) begin
          if (r_bit_cnt == 5'd5) begin
            w_state_nx = S_DATA;
            w_bit_nx   = '0;
          end else begin
            w_bit_nx = r_bit_cnt + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_second_nx = ~r_second;
          if (r_second) begin
            w_data_nx = {r_data[14:0], 1'b0};
            if (r_bit_cnt == 5'd15) begin
`ifdef EDIB_M2_TX_PARITY_EN
              w_state_nx = S_PARITY;
`else
              w_state_nx = S_GAP;
`endif
              w_bit_nx = '0;
            end else begin
              w_bit_nx = r_bit_cnt + 5'd1;
            end
          end
        end
      end
`ifdef EDIB_M2_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_second_nx = ~r_second;
          if (r_second) begin
            w_state_nx = S_GAP;
            w_bit_nx   = '0;
          end
        end
      end
`endif
      S_GAP: begin
        if (w_tick) begin
          if (r_bit_cnt == GAP_LAST) begin
            w_state_nx = S_IDLE;
            w_bit_nx   = '0;
          end else begin
            w_bit_nx = r_bit_cnt + 5'd1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so the first sync half-bit follows the handshake directly.
  always_comb begin
    w_line_nx  = 1'b0;
    w_drive_nx = 1'b0;
    case (w_state_nx)
      S_SYNC: begin
        w_drive_nx = 1'b1;
        w_line_nx  = w_cmd_nx ? (w_bit_nx < 5'd3) : (w_bit_nx >= 5'd3);
      end
      S_DATA: begin
        w_drive_nx = 1'b1;
        w_line_nx  = w_data_nx[15] ^ w_second_nx;
      end
`ifdef EDIB_M2_TX_PARITY_EN
      S_PARITY: begin
        w_drive_nx = 1'b1;
        w_line_nx  = r_par ^ w_second_nx;
      end
`endif
      default: begin
        w_drive_nx = 1'b0;
        w_line_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_second   <= 1'b0;
      r_data     <= '0;
      r_cmd      <= 1'b0;
      r_ready    <= 1'b0;
      r_p        <= 1'b0;
      r_n        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_half_cnt <= w_half_nx;
      r_bit_cnt  <= w_bit_nx;
      r_second   <= w_second_nx;
      r_data     <= w_data_nx;
      r_cmd      <= w_cmd_nx;
      r_ready    <= enable && (w_state_nx == S_IDLE);
      r_p        <= w_drive_nx & w_line_nx;
      r_n        <= w_drive_nx & ~w_line_nx;
      r_busy     <= (w_state_nx != S_IDLE);
      r_done     <= (w_state_nx == S_GAP) && (r_state != S_GAP);
    end
  end

`ifdef EDIB_M2_TX_PARITY_EN
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      r_par <= 1'b0;
    end else if (w_hs) begin
      r_par <= ~^tx_data;
    end
  end
`endif

  assign tx_ready = r_ready;
  assign tx_p     = r_p;
  assign tx_n     = r_n;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule
